// File: rtl/aes_ks_pkg.sv
// -----------------------------------------------------------------------------
// aes_ks_pkg
// Shared types, constants and byte-level helpers for the AES key-schedule
// controller (aes_key_sched_ctrl) and its round-key generator (aes_roundkey).
//   ks_state_e         : controller FSM states
//   MODE_128/MODE_256  : key_mode encodings accepted by the controller
//   LAST_RD_128/256    : index of the final round key per key size
//   rk_t               : one 128-bit round key, w0 at the MSBs
//   sbox/sub_word/rcon : AES forward S-box and round constants
// -----------------------------------------------------------------------------
package aes_ks_pkg;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_e;

  localparam logic [1:0] MODE_128    = 2'b00;
  localparam logic [1:0] MODE_256    = 2'b10;

  localparam logic [3:0] LAST_RD_128 = 4'd10;
  localparam logic [3:0] LAST_RD_256 = 4'd14;

  typedef logic [127:0] rk_t;

  // Forward S-box, entry 0x00 in the top byte, entry 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant for key-word group idx (1-based); only 1..10 are ever used.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_roundkey.sv
// -----------------------------------------------------------------------------
// aes_roundkey
// Combinational generator for one 128-bit round key of the AES key expansion.
// Ports:
//   i_rd          in  4    index of the round key being produced (1..14)
//   i_mode        in  2    MODE_128 or MODE_256
//   i_prev_key    in  128  rk[i_rd-1] (AES-128) or rk[i_rd-2] (AES-256)
//   i_cur_key     in  128  rk[i_rd-1]
//   o_round_key   out 128  rk[i_rd]
// For AES-128 both key inputs carry the same value, so one formula covers
// both sizes: the new first word is the word Nk positions back (prev_key w0)
// xored with a transform of the most recent word (cur_key w3).
// -----------------------------------------------------------------------------
module aes_roundkey
  import aes_ks_pkg::*;
(
  input  logic [3:0] i_rd,
  input  logic [1:0] i_mode,
  input  rk_t        i_prev_key,
  input  rk_t        i_cur_key,
  output rk_t        o_round_key
);

  logic        w_is256;
  logic        w_rot;
  logic [3:0]  w_rcon_idx;
  logic [31:0] w_last;
  logic [31:0] w_sub_in;
  logic [31:0] w_temp;
  logic [31:0] w_0;
  logic [31:0] w_1;
  logic [31:0] w_2;
  logic [31:0] w_3;

  assign w_is256 = (i_mode == MODE_256);

  // AES-256 alternates: even round keys start an 8-word group (rotate + rcon),
  // odd round keys start the mid-group word (SubWord only).
  assign w_rot      = !w_is256 || !i_rd[0];
  assign w_rcon_idx = w_is256 ? {1'b0, i_rd[3:1]} : i_rd;

  assign w_last   = i_cur_key[31:0];
  assign w_sub_in = w_rot ? {w_last[23:0], w_last[31:24]} : w_last;
  assign w_temp   = sub_word(w_sub_in) ^
                    (w_rot ? {rcon(w_rcon_idx), 24'h000000} : 32'h00000000);

  assign w_0 = i_prev_key[127:96] ^ w_temp;
  assign w_1 = i_prev_key[95:64]  ^ w_0;
  assign w_2 = i_prev_key[63:32]  ^ w_1;
  assign w_3 = i_prev_key[31:0]   ^ w_2;

  assign o_round_key = {w_0, w_1, w_2, w_3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_sched_ctrl
// Iterative AES-128/AES-256 key-expansion controller. A loaded cipher key is
// expanded one round key per cycle through a single aes_roundkey instance into
// a flop-based store of NUM_RK entries, then served by index to the round
// datapath (decryption simply reads indices in descending order).
//
// Build option: define AES_KS_ZEROIZE_EN to add the zeroize input, which
// clears the store and latched mode and returns the FSM to idle.
//
// Ports:
//   clk          in   1    clock, rising edge
//   rst_n        in   1    asynchronous active-low reset
//   zeroize      in   1    (AES_KS_ZEROIZE_EN only) wipe schedule, highest priority
//   key_valid    in   1    key load request
//   key_ready    out  1    key can be accepted (idle or done)
//   key_mode     in   2    00 AES-128, 10 AES-256, others rejected
//   key_in       in   256  key, w0 at MSBs; AES-128 uses [255:128]
//   busy         out  1    expansion in progress
//   done         out  1    one-cycle pulse on entering done
//   sched_valid  out  1    full schedule present and readable
//   mode_err     out  1    sticky bad-mode flag, cleared by a good load
//   rk_rd_en     in   1    round-key read strobe
//   rk_rd_idx    in   4    round-key index
//   rk_rd_data   out  128  registered read data (0 on error)
//   rk_rd_err    out  1    registered read error
//   dbg_state    out  2    current FSM state
//
// Handshake: a key is taken on any rising edge where key_valid && key_ready;
// key_ready depends only on the FSM state, never on key_valid. A bad mode is
// still taken (consumed) but only raises mode_err and leaves the FSM idle.
// -----------------------------------------------------------------------------
module aes_key_sched_ctrl
  import aes_ks_pkg::*;
#(
  parameter int NUM_RK = 15
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_KS_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [1:0]   key_mode,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         sched_valid,
  output logic         mode_err,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_idx,
  output rk_t          rk_rd_data,
  output logic         rk_rd_err,
  output ks_state_e    dbg_state
);

  ks_state_e  r_state;
  ks_state_e  w_state_nxt;
  logic [1:0] r_mode;
  logic [3:0] r_rd;
  rk_t        r_rk [NUM_RK];
  logic       r_sched_valid;
  logic       r_mode_err;
  logic       r_done;
  rk_t        r_rd_data;
  logic       r_rd_err;

  logic       w_zeroize;
  logic       w_key_ready;
  logic       w_accept;
  logic       w_mode_ok;
  logic       w_load_ok;
  logic       w_load_bad;
  logic       w_is256;
  logic [3:0] w_last_rd;
  logic       w_expand;
  logic       w_last_write;
  logic [3:0] w_cur_idx;
  logic [3:0] w_prev_idx;
  rk_t        w_cur_key;
  rk_t        w_prev_key;
  rk_t        w_round_key;
  rk_t        w_rd_sel;
  logic       w_rd_bad;

`ifdef AES_KS_ZEROIZE_EN
  assign w_zeroize = zeroize;
`else
  assign w_zeroize = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Load decode
  // ---------------------------------------------------------------------------
  assign w_key_ready  = (r_state == KS_IDLE) || (r_state == KS_DONE);
  assign w_accept     = key_valid && w_key_ready && !w_zeroize;
  assign w_mode_ok    = (key_mode == MODE_128) || (key_mode == MODE_256);
  assign w_load_ok    = w_accept && w_mode_ok;
  assign w_load_bad   = w_accept && !w_mode_ok;

  assign w_is256      = (r_mode == MODE_256);
  assign w_last_rd    = w_is256 ? LAST_RD_256 : LAST_RD_128;
  assign w_expand     = (r_state == KS_EXPAND);
  assign w_last_write = w_expand && (r_rd == w_last_rd);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= KS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      KS_IDLE, KS_DONE: begin
        if (w_load_ok) begin
          w_state_nxt = KS_EXPAND;
        end else if (w_load_bad) begin
          w_state_nxt = KS_IDLE;
        end
      end
      KS_EXPAND: begin
        if (w_last_write) begin
          w_state_nxt = KS_DONE;
        end
      end
      default: w_state_nxt = KS_IDLE;
    endcase
    if (w_zeroize) begin
      w_state_nxt = KS_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= MODE_128;
      r_rd          <= 4'd0;
      r_sched_valid <= 1'b0;
      r_mode_err    <= 1'b0;
      r_done        <= 1'b0;
    end else if (w_zeroize) begin
      r_mode        <= MODE_128;
      r_sched_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_last_write;
      if (w_load_ok) begin
        r_mode        <= key_mode;
        // AES-256 loads two round keys straight from the key.
        r_rd          <= (key_mode == MODE_256) ? 4'd2 : 4'd1;
        r_sched_valid <= 1'b0;
        r_mode_err    <= 1'b0;
      end else if (w_load_bad) begin
        r_mode_err    <= 1'b1;
        r_sched_valid <= 1'b0;
      end else if (w_expand) begin
        r_rd <= r_rd + 4'd1;
        if (w_last_write) begin
          r_sched_valid <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-key generation: two concurrent store reads feed the generator.
  // ---------------------------------------------------------------------------
  assign w_cur_idx  = r_rd - 4'd1;
  assign w_prev_idx = w_is256 ? (r_rd - 4'd2) : (r_rd - 4'd1);

  always_comb begin
    w_cur_key  = '0;
    w_prev_key = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (w_cur_idx == 4'(i)) begin
        w_cur_key = r_rk[i];
      end
      if (w_prev_idx == 4'(i)) begin
        w_prev_key = r_rk[i];
      end
    end
  end

  aes_roundkey u_roundkey (
    .i_rd        (r_rd),
    .i_mode      (r_mode),
    .i_prev_key  (w_prev_key),
    .i_cur_key   (w_cur_key),
    .o_round_key (w_round_key)
  );

  // ---------------------------------------------------------------------------
  // Round-key store. Contents are meaningless unless r_sched_valid, so no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_zeroize) begin
      for (int i = 0; i < NUM_RK; i++) begin
        r_rk[i] <= '0;
      end
    end else if (w_load_ok) begin
      r_rk[0] <= key_in[255:128];
      if (key_mode == MODE_256) begin
        r_rk[1] <= key_in[127:0];
      end
    end else if (w_expand) begin
      for (int i = 0; i < NUM_RK; i++) begin
        if (r_rd == 4'(i)) begin
          r_rk[i] <= w_round_key;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read port. Uses the registered sched_valid/store, so a read in the same
  // cycle as a reload sees the schedule that was there before the load.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (rk_rd_idx == 4'(i)) begin
        w_rd_sel = r_rk[i];
      end
    end
  end

  assign w_rd_bad = !r_sched_valid || (rk_rd_idx > w_last_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_rd_err  <= 1'b0;
    end else if (rk_rd_en) begin
      r_rd_err  <= w_rd_bad;
      r_rd_data <= w_rd_bad ? '0 : w_rd_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign key_ready   = w_key_ready;
  assign busy        = w_expand;
  assign done        = r_done;
  assign sched_valid = r_sched_valid;
  assign mode_err    = r_mode_err;
  assign rk_rd_data  = r_rd_data;
  assign rk_rd_err   = r_rd_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
// Directed + randomized bench for aes_key_sched_ctrl. The expected schedule
// comes from a word-level FIPS-197 key expansion whose S-box is derived from
// GF(2^8) inversion and the affine map, and whose round constants come from
// repeated doubling. Zeroize steps are included when AES_KS_ZEROIZE_EN is set.
// -----------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;
  import aes_ks_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [1:0]   key_mode;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         sched_valid;
  logic         mode_err;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic         rk_rd_err;
  ks_state_e    dbg_state;
`ifdef AES_KS_ZEROIZE_EN
  logic         zeroize;
`endif

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize     (zeroize),
`endif
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_mode    (key_mode),
    .key_in      (key_in),
    .busy        (busy),
    .done        (done),
    .sched_valid (sched_valid),
    .mode_err    (mode_err),
    .rk_rd_en    (rk_rd_en),
    .rk_rd_idx   (rk_rd_idx),
    .rk_rd_data  (rk_rd_data),
    .rk_rd_err   (rk_rd_err),
    .dbg_state   (dbg_state)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0]   tb_sbox [256];
  logic [127:0] m_rk [15];
  int           m_last  = 10;
  bit           m_valid = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  logic [128:0] exp_q [$];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    logic [7:0] base;
    int         e;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      base = 8'(v);
      e = 254;
      while (e > 0) begin
        if (e[0]) inv = gf_mul(inv, base);
        base = gf_mul(base, base);
        e = e >> 1;
      end
      if (v == 0) inv = 8'h00;
      tb_sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                   {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] tb_sub_word(input logic [31:0] w);
    return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
  endfunction

  function automatic void model_expand(input logic [255:0] key, input bit is256);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    int nr;
    nk = is256 ? 8 : 4;
    nr = is256 ? 14 : 10;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = tb_sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = tb_sub_word(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    m_last = nr;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_key_ready"},   key_ready,   1'b1);
    check({tag, "_busy"},        busy,        1'b0);
    check({tag, "_done"},        done,        1'b0);
    check({tag, "_sched_valid"}, sched_valid, 1'b0);
    check({tag, "_mode_err"},    mode_err,    1'b0);
    check({tag, "_rd_err"},      rk_rd_err,   1'b0);
    check({tag, "_rd_data"},     rk_rd_data,  128'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic start_load(input logic [1:0] mode, input logic [255:0] key);
    key_valid = 1'b1;
    key_mode  = mode;
    key_in    = key;
    @(negedge clk);
    key_valid = 1'b0;
    m_valid   = 1'b0;
  endtask

  task automatic finish_load(input logic [255:0] key, input bit is256, input int start,
                             input string tag);
    int n;
    n = start;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 128'(n), is256 ? 128'd13 : 128'd10);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_sched_valid"}, sched_valid, 1'b1);
    check({tag, "_busy_low"}, busy, 1'b0);
    model_expand(key, is256);
    m_valid = 1'b1;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_sched_hold"}, sched_valid, 1'b1);
    check({tag, "_key_ready"}, key_ready, 1'b1);
  endtask

  task automatic rd_issue(input logic [3:0] idx, input string tag);
    logic [128:0] item;
    if (!m_valid || int'(idx) > m_last) exp_q.push_back({1'b1, 128'h0});
    else                                exp_q.push_back({1'b0, m_rk[idx]});
    rk_rd_en  = 1'b1;
    rk_rd_idx = idx;
    @(negedge clk);
    rk_rd_en  = 1'b0;
    item = exp_q.pop_front();
    check({tag, "_err"},  rk_rd_err,  item[128]);
    check({tag, "_data"}, rk_rd_data, item[127:0]);
  endtask

  task automatic rd_desc(input string tag);
    for (int i = m_last; i >= 0; i--) rd_issue(4'(i), tag);
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[j*32 +: 32] = $urandom();
    return k;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [255:0] FIPS_128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] FIPS_256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0] k;
    logic [255:0] k2;
    logic [127:0] old_rk5;
    logic [1:0]   md;
    logic [3:0]   bad_idx;
    bit           b256;

    build_sbox();
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_mode  = 2'b00;
    key_in    = '0;
    rk_rd_en  = 1'b0;
    rk_rd_idx = 4'd0;
`ifdef AES_KS_ZEROIZE_EN
    zeroize   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_key_ready", key_ready, 1'b1);

    // AES-128 known answer
    start_load(MODE_128, FIPS_128);
    check("k128_busy", busy, 1'b1);
    check("k128_not_ready", key_ready, 1'b0);
    finish_load(FIPS_128, 1'b0, 0, "k128");
    rd_issue(4'd10, "k128_rk10");
    check("k128_rk10_fips", rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_desc("k128_desc");
    rd_issue(4'd11, "k128_idx11");
    rd_issue(4'd15, "k128_idx15");
    @(negedge clk);
    check("rd_hold_err",  rk_rd_err,  1'b1);
    check("rd_hold_data", rk_rd_data, 128'h0);

    // AES-256 known answer
    start_load(MODE_256, FIPS_256);
    finish_load(FIPS_256, 1'b1, 0, "k256");
    rd_issue(4'd14, "k256_rk14");
    check("k256_rk14_fips", rk_rd_data, 128'hfe4890d1e6188d0b046df344706c631e);
    rd_issue(4'd0, "k256_rk0");
    check("k256_rk0_key", rk_rd_data, FIPS_256[255:128]);
    rd_issue(4'd1, "k256_rk1");
    check("k256_rk1_key", rk_rd_data, FIPS_256[127:0]);
    rd_desc("k256_desc");
    rd_issue(4'd15, "k256_idx15");

    // Unsupported modes
    start_load(2'b01, rand_key());
    check("bad01_mode_err", mode_err, 1'b1);
    check("bad01_sched", sched_valid, 1'b0);
    check("bad01_ready", key_ready, 1'b1);
    check("bad01_busy", busy, 1'b0);
    rd_issue(4'd0, "bad01_rd");
    start_load(2'b11, rand_key());
    check("bad11_mode_err", mode_err, 1'b1);
    check("bad11_busy", busy, 1'b0);
    k = rand_key();
    start_load(MODE_128, k);
    check("good_clears_err", mode_err, 1'b0);
    finish_load(k, 1'b0, 0, "after_bad");
    rd_desc("after_bad_desc");

    // Read and reload in the same cycle sees the previous schedule
    old_rk5   = m_rk[5];
    k2        = rand_key();
    rk_rd_en  = 1'b1;
    rk_rd_idx = 4'd5;
    key_valid = 1'b1;
    key_mode  = MODE_256;
    key_in    = k2;
    @(negedge clk);
    rk_rd_en  = 1'b0;
    key_valid = 1'b0;
    m_valid   = 1'b0;
    check("rdload_err",  rk_rd_err,  1'b0);
    check("rdload_data", rk_rd_data, old_rk5);
    check("rdload_busy", busy, 1'b1);
    rd_issue(4'd2, "expand_rd");
    finish_load(k2, 1'b1, 1, "rdload");
    rd_desc("rdload_desc");

    // Reset in the middle of an expansion
    start_load(MODE_128, rand_key());
    repeat (3) @(negedge clk);
    rd_issue(4'd0, "pre_rst_rd");
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    @(negedge clk);
    rst_n   = 1'b1;
    m_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", key_ready, 1'b1);
    k = rand_key();
    start_load(MODE_256, k);
    finish_load(k, 1'b1, 0, "post_rst");
    rd_desc("post_rst_desc");

    // Randomized loads, with key_valid asserted (ignored) during expansion
    for (int it = 0; it < 6; it++) begin
      b256 = ($urandom_range(0, 1) == 1);
      md   = b256 ? MODE_256 : MODE_128;
      k    = rand_key();
      start_load(md, k);
      key_valid = 1'b1;
      key_mode  = MODE_128;
      key_in    = rand_key();
      rd_issue(4'($urandom_range(0, 15)), "rnd_expand_rd");
      repeat (2) @(negedge clk);
      key_valid = 1'b0;
      finish_load(k, b256, 3, "rnd");
      rd_desc("rnd_desc");
      bad_idx = 4'($urandom_range(m_last + 1, 15));
      rd_issue(bad_idx, "rnd_oob");
    end

`ifdef AES_KS_ZEROIZE_EN
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    m_valid = 1'b0;
    check("zero_sched", sched_valid, 1'b0);
    check("zero_busy",  busy, 1'b0);
    check("zero_done",  done, 1'b0);
    rd_issue(4'd0, "zero_rd");
    zeroize   = 1'b1;
    key_valid = 1'b1;
    key_mode  = MODE_128;
    key_in    = rand_key();
    @(negedge clk);
    zeroize   = 1'b0;
    key_valid = 1'b0;
    check("zero_blocks_busy",  busy, 1'b0);
    check("zero_blocks_ready", key_ready, 1'b1);
    k = rand_key();
    start_load(MODE_128, k);
    finish_load(k, 1'b0, 0, "zero_reload");
    rd_issue(4'd0, "zero_reload_rk0");
    check("zero_reload_key", rk_rd_data, k[255:128]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
